piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in/serial-out serializer, the next generation of the team's fixed 4-bit load/shift register. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, in a per-word selectable bit order, with frame-start and frame-last markers. Back-to-back frames stream with no idle gap. It sits between a parallel data source and a single-wire serial sink, such as an LED chain or a serial link model.

## Interface
- WIDTH, 8: data word width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1): bit-counter width; derived, never overridden.

- clock  input  1  single clock domain; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset. Assertion takes effect immediately; deassertion is used synchronously to clock.
- load_valid  input  1  source offers data_in this cycle.
- load_ready  output  1  block accepts a word this cycle; combinational.
- data_in  input  WIDTH  parallel word; sampled on accept.
- msb_first  input  1  bit order for the word being accepted; 1 = bit WIDTH-1 first, 0 = bit 0 first; sampled on accept.
- ser_out  output  1  serial data bit; registered.
- ser_valid  output  1  ser_out carries a frame bit; registered.
- frame_start  output  1  high with the first bit of each frame; registered.
- frame_last  output  1  high with the final bit of each frame; registered.
- busy  output  1  a frame is in progress; equals ser_valid.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame in progress. Holds shift register sreg[WIDTH-1:0], bit counter cnt[CNT_W-1:0] and latched order bit ord.
- Accept: the word is taken on any rising edge where load_valid & load_ready.
  - sreg <= data_in, ord <= msb_first, cnt <= 0.
  - Next state is SHIFT.
- load_ready = (state==IDLE) | (state==SHIFT & frame_last). The block accepts a new word during the last bit of the current frame, so frames stream back-to-back.
- SHIFT, each cycle:
  - ser_out presents sreg[WIDTH-1] if ord=1, else sreg[0].
  - Each following edge shifts sreg toward the output end, fills with 0, and increments cnt.
- frame_start is high when cnt==0. frame_last is high when cnt==FRAME_LEN-1.
  - FRAME_LEN = WIDTH, or WIDTH+1 with parity enabled (see Configuration).
- End of frame, on the edge after the frame_last cycle:
  - If a word is accepted on that edge, the block reloads and stays in SHIFT.
  - Otherwise it returns to IDLE with ser_valid=0.
- In IDLE: ser_out=0, frame_start=0, frame_last=0.
- data_in and msb_first are ignored whenever they are not accepted. Changing them mid-frame has no effect.

## Timing
- Reset values: state IDLE, ser_out=0, ser_valid=0, frame_start=0, frame_last=0, busy=0, sreg=0, cnt=0.
- load_ready reads 1 while reset_n=0 (state is IDLE). No word is captured while reset_n=0.
- Latency: the first serial bit appears the cycle after the accept edge.
- Frame duration: exactly FRAME_LEN cycles of ser_valid=1.
- Back-to-back throughput: one word every FRAME_LEN cycles with no ser_valid gap. frame_last of frame N is immediately followed by frame_start of frame N+1.
- Reset mid-frame: the frame is aborted immediately. No partial bit, frame_last or pulse is emitted after reset is released.
- load_valid held high in IDLE: the word is accepted on the first edge; the next word is accepted at the following frame_last.
- WIDTH=2 is legal: frames are 2 bits (3 with parity). frame_start and frame_last are never both high.

## Configuration
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH bits of the accepted word) is computed and latched at accept.
  - The parity bit is emitted as one extra bit after the data bits.
  - FRAME_LEN = WIDTH+1. frame_last is high on the parity bit only.
- Undefined:
  - No parity logic is present. FRAME_LEN = WIDTH; frame_last is high on the final data bit.
- Handshake, bit order and all other behaviour are identical in both builds.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles with load_valid=1 and data_in=0xA5 -> outputs stay at reset values and nothing is captured.
- **MSB-first frame:** WIDTH=8, data_in=0xA5, msb_first=1, single accept -> ser_out is 1,0,1,0,0,1,0,1 on the 8 cycles after accept; frame_start on bit 1; frame_last on bit 8; ser_valid=0 on the following cycle.
- **LSB-first frame:** data_in=0xA5, msb_first=0 -> ser_out is 1,0,1,0,0,1,0,1 (0xA5 is palindromic). Repeat with 0x01 -> ser_out is 1,0,0,0,0,0,0,0.
- **Back-to-back streaming:** load_valid held high for words 0xF0 then 0x0F -> 16 consecutive ser_valid=1 cycles; load_ready high only in IDLE and on each frame_last; frame_start at cycles 1 and 9.
- **Reset mid-frame:** pulse reset_n low at bit 4 of 0xFF -> ser_valid=0 immediately; after release the block is in IDLE and accepts 0x00 normally.
- **Parity build:** with PISO_SERIALIZER_PARITY_EN, data_in=0x07 -> 8 data bits followed by parity 1 as a 9th bit with frame_last; data_in=0x03 -> parity 0.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parametrised parallel-in/serial-out shifter with a
// valid/ready load port, per-word bit order and frame start/last markers.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN appends an even-parity
// bit after the data bits of every frame.
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_first,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ord, ord_n;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par, par_n;
`endif
  logic             accept;
  logic             bit_n, sv_n, fs_n, fl_n;

  // frame_last is only ever high in SHIFT, so it doubles as "last bit now"
  assign load_ready = (state == IDLE) | frame_last;
  assign accept     = load_valid & load_ready;
  assign busy       = ser_valid;

  // Next-state: accept reloads, otherwise shift toward the output end or finish
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    ord_n   = ord;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_n   = par;
`endif
    if (accept) begin
      state_n = SHIFT;
      sreg_n  = data_in;
      cnt_n   = '0;
      ord_n   = msb_first;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_n   = ^data_in;
`endif
    end else if (state == SHIFT) begin
      if (cnt == LAST_CNT) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        sreg_n = ord ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        cnt_n  = cnt + 1'b1;
      end
    end
  end

  // Output values for the next cycle, derived from the next state so the
  // serial outputs can come straight from flops
  always_comb begin
    sv_n  = (state_n == SHIFT);
    bit_n = ord_n ? sreg_n[WIDTH-1] : sreg_n[0];
`ifdef PISO_SERIALIZER_PARITY_EN
    if (cnt_n == CNT_W'(WIDTH)) bit_n = par_n;
`endif
    bit_n = bit_n & sv_n;
    fs_n  = sv_n & (cnt_n == '0);
    fl_n  = sv_n & (cnt_n == LAST_CNT);
  end

  // State and registered serial outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      ord         <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par         <= 1'b0;
`endif
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      cnt         <= cnt_n;
      ord         <= ord_n;
`ifdef PISO_SERIALIZER_PARITY_EN
      par         <= par_n;
`endif
      ser_out     <= bit_n;
      ser_valid   <= sv_n;
      frame_start <= fs_n;
      frame_last  <= fl_n;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed and random checks of piso_serializer against
// a frame-queue reference model (each accepted word expands into a list of
// {bit, start, last} items that are replayed one per clock).
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] data_in = '0;
  logic         msb_first = 1'b0;
  logic         ser_out, ser_valid, frame_start, frame_last, busy;
  logic [5:0]   act;

  int n_checks = 0;
  int n_fail   = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .load_valid(load_valid),
    .load_ready(load_ready), .data_in(data_in), .msb_first(msb_first),
    .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
    .frame_last(frame_last), .busy(busy)
  );

  always #5 clock = ~clock;

  assign act = {ser_valid, ser_out, frame_start, frame_last, busy, load_ready};

  // reference model: current item on the wire plus the rest of the frame
  typedef struct packed { logic b; logic s; logic l; } item_t;
  item_t q[$];
  item_t cur;
  bit    cur_v = 1'b0;

  function automatic logic [5:0] expv();
    return {cur_v, cur_v & cur.b, cur_v & cur.s, cur_v & cur.l, cur_v,
            !cur_v || cur.l};
  endfunction

  function automatic void push_frame(logic [W-1:0] d, logic msb);
    item_t it;
    for (int i = 0; i < W; i++) begin
      it.b = msb ? d[W-1-i] : d[i];
      it.s = (i == 0);
      it.l = (i == FL - 1);
      q.push_back(it);
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    it.b = ^d; it.s = 1'b0; it.l = 1'b1;
    q.push_back(it);
`endif
  endfunction

  function automatic void model_reset();
    cur_v = 1'b0;
    q.delete();
  endfunction

  // one clock: model follows the inputs present at the rising edge,
  // returns with outputs settled at the falling edge
  task automatic step(output bit acc);
    bit rdy;
    rdy = !cur_v || cur.l;
    @(posedge clock);
    acc = reset_n && load_valid && rdy;
    if (!reset_n) model_reset();
    else begin
      if (acc) push_frame(data_in, msb_first);
      if (q.size() > 0) begin cur = q.pop_front(); cur_v = 1'b1; end
      else cur_v = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic send(input logic [W-1:0] d, input logic msb, output bit acc);
    load_valid = 1'b1; data_in = d; msb_first = msb;
    step(acc);
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit acc;
    reset_n = 1'b0; load_valid = 1'b1; data_in = 8'hA5; msb_first = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      n_checks++;
      if (act !== 6'b000001) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got %b want 000001", i, act);
      end
    end
    load_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
    step(acc);
    n_checks++;
    if (act !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 000001", act);
    end
  endtask

  // one isolated frame; compares every cycle and the assembled bit string
  task automatic test_frame(input string nm, input logic [W-1:0] d,
                            input logic msb, input logic [W-1:0] want_bits);
    bit acc;
    logic [W-1:0] got;
    got = '0;
    send(d, msb, acc);
    for (int i = 0; i < FL; i++) begin
      if (i > 0) step(acc);
      n_checks++;
      if (act !== expv()) begin
        n_fail++;
        $display("FAIL %s bit%0d: got %b want %b", nm, i + 1, act, expv());
      end
      if (i < W) got = {got[W-2:0], ser_out};
    end
    step(acc);
    n_checks++;
    if (ser_valid !== 1'b0 || act !== expv()) begin
      n_fail++;
      $display("FAIL %s tail: got %b want %b", nm, act, expv());
    end
    n_checks++;
    if (got !== want_bits) begin
      n_fail++;
      $display("FAIL %s bits: got %h want %h", nm, got, want_bits);
    end
  endtask

  task automatic test_msb_frame();
    test_frame("msb_a5", 8'hA5, 1'b1, 8'hA5);
  endtask

  task automatic test_lsb_frame();
    test_frame("lsb_a5", 8'hA5, 1'b0, 8'hA5);
    test_frame("lsb_01", 8'h01, 1'b0, 8'h80);
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n_acc, n_sv, s1, s2, ns;
    n_acc = 0; n_sv = 0; s1 = -1; s2 = -1; ns = 0;
    load_valid = 1'b1; data_in = 8'hF0; msb_first = 1'b1;
    for (int c = 1; c <= 2 * FL + 1; c++) begin
      step(acc);
      if (acc) begin
        n_acc++;
        data_in = 8'h0F;
        if (n_acc == 2) load_valid = 1'b0;
      end
      n_checks++;
      if (act !== expv()) begin
        n_fail++;
        $display("FAIL b2b cyc%0d: got %b want %b", c, act, expv());
      end
      if (ser_valid) n_sv++;
      if (frame_start) begin
        if (ns == 0) s1 = c; else s2 = c;
        ns++;
      end
    end
    n_checks++;
    if (n_sv !== 2 * FL || n_acc !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: got valid=%0d acc=%0d want valid=%0d acc=2",
               n_sv, n_acc, 2 * FL);
    end
    n_checks++;
    if (s1 !== 1 || s2 !== FL + 1 || ns !== 2) begin
      n_fail++;
      $display("FAIL b2b_starts: got %0d,%0d (n=%0d) want 1,%0d", s1, s2, ns, FL + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit acc;
    send(8'hFF, 1'b1, acc);
    for (int i = 1; i < 4; i++) step(acc);
    n_checks++;
    if (act !== expv() || ser_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_bit4: got %b want %b", act, expv());
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (act !== 6'b000001) begin
      n_fail++;
      $display("FAIL midrst_async: got %b want 000001", act);
    end
    step(acc);
    reset_n = 1'b1;
    step(acc);
    n_checks++;
    if (act !== 6'b000001) begin
      n_fail++;
      $display("FAIL midrst_idle: got %b want 000001", act);
    end
    test_frame("midrst_00", 8'h00, 1'b1, 8'h00);
  endtask

`ifdef PISO_SERIALIZER_PARITY_EN
  task automatic test_parity();
    bit acc;
    logic [1:0] want [2];
    logic [W-1:0] words [2];
    want[0] = 2'b11; want[1] = 2'b10;   // {parity, last}
    words[0] = 8'h07; words[1] = 8'h03;
    for (int k = 0; k < 2; k++) begin
      send(words[k], 1'b1, acc);
      for (int i = 1; i < FL; i++) step(acc);
      n_checks++;
      if ({ser_out, frame_last} !== want[k] || act !== expv()) begin
        n_fail++;
        $display("FAIL parity_%h: got out/last %b want %b", words[k],
                 {ser_out, frame_last}, want[k]);
      end
      step(acc);
    end
  endtask
`endif

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 400; c++) begin
      load_valid = ($urandom_range(0, 9) < 6);
      data_in    = W'($urandom);
      msb_first  = $urandom_range(0, 1);
      step(acc);
      n_checks++;
      if (act !== expv()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %b want %b", c, act, expv());
      end
    end
    load_valid = 1'b0;
    for (int c = 0; c < FL + 1; c++) step(acc);
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_lsb_frame();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef PISO_SERIALIZER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
